// File: rtl/reg_file_param.sv
// Clocked two-read/one-write register bank with per-register pending bits.
// Read ports can be combinational or registered, with optional write forwarding.

module reg_file_param_rdport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_READ = 0
) (
    input  logic [ADDR_W-1:0]                    addr,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]     mem,
    input  logic [2**ADDR_W-1:0]                 busy,
    input  logic                                 wr_ok,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    input  logic                                 set_ok,
    input  logic [ADDR_W-1:0]                    set_addr,
    output logic [DATA_W-1:0]                    data,
    output logic                                 pend
);
    logic wr_hit, set_hit;

    assign wr_hit  = wr_ok && (wr_addr == addr);
    assign set_hit = set_ok && (set_addr == addr);

    // Combinational bypass forwards only the busy-clear; a registered bypass
    // samples the full next state, so a lone busy-set is visible too.
    always_comb begin
        data = mem[addr];
        pend = busy[addr];
        if (BYPASS != 0 && wr_hit) begin
            data = wr_data;
            pend = set_hit;
        end
        if (BYPASS != 0 && REG_READ != 0 && set_hit)
            pend = 1'b1;
        if (ZERO_REG != 0 && addr == '0) begin
            data = '0;
            pend = 1'b0;
        end
    end
endmodule

module reg_file_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int REG_READ = 0
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [ADDR_W-1:0] RD_ADDR1,
    input  logic [ADDR_W-1:0] RD_ADDR2,
    output logic [DATA_W-1:0] RD_DATA1,
    output logic [DATA_W-1:0] RD_DATA2,
    output logic              RD_BUSY1,
    output logic              RD_BUSY2,
    input  logic              WR_EN,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [DATA_W-1:0] WR_DATA,
    input  logic              BUSY_SET,
    input  logic [ADDR_W-1:0] BUSY_ADDR
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int PORTS = 2;

    logic [DEPTH-1:0][DATA_W-1:0] mem;
    logic [DEPTH-1:0]             busy;
    logic                         wr_ok, set_ok;

    assign wr_ok  = WR_EN    && !(ZERO_REG != 0 && WR_ADDR   == '0);
    assign set_ok = BUSY_SET && !(ZERO_REG != 0 && BUSY_ADDR == '0);

    // Busy-set is assigned last so a younger load wins over a retiring write.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mem  <= '0;
            busy <= '0;
        end else begin
            if (wr_ok) begin
                mem[WR_ADDR]  <= WR_DATA;
                busy[WR_ADDR] <= 1'b0;
            end
            if (set_ok)
                busy[BUSY_ADDR] <= 1'b1;
        end
    end

    logic [PORTS-1:0][ADDR_W-1:0] rd_addr;
    logic [PORTS-1:0][DATA_W-1:0] sel_data;
    logic [PORTS-1:0]             sel_pend;

    assign rd_addr = {RD_ADDR2, RD_ADDR1};

    for (genvar p = 0; p < PORTS; p++) begin : g_port
        reg_file_param_rdport #(
            .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG),
            .BYPASS(BYPASS), .REG_READ(REG_READ)
        ) u_port (
            .addr(rd_addr[p]), .mem(mem), .busy(busy),
            .wr_ok(wr_ok), .wr_addr(WR_ADDR), .wr_data(WR_DATA),
            .set_ok(set_ok), .set_addr(BUSY_ADDR),
            .data(sel_data[p]), .pend(sel_pend[p])
        );
    end

    if (REG_READ != 0) begin : g_reg
        logic [PORTS-1:0][DATA_W-1:0] data_q;
        logic [PORTS-1:0]             pend_q;

        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) begin
                data_q <= '0;
                pend_q <= '0;
            end else begin
                data_q <= sel_data;
                pend_q <= sel_pend;
            end
        end

        assign RD_DATA1 = data_q[0];
        assign RD_DATA2 = data_q[1];
        assign RD_BUSY1 = pend_q[0];
        assign RD_BUSY2 = pend_q[1];
    end else begin : g_comb
        assign RD_DATA1 = sel_data[0];
        assign RD_DATA2 = sel_data[1];
        assign RD_BUSY1 = sel_pend[0];
        assign RD_BUSY2 = sel_pend[1];
    end
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised, clocked general-purpose register bank for the MIPS-style datapath; next generation of the combinational register block.
- Two read ports and one write port; writes occur on clock edges.
- Optional register-zero hardwiring and write-to-read bypass.
- Per-register pending (scoreboard) bit: a load in flight marks its destination busy, and the decode stage stalls on it.

Parameters:
- DATA_W, 32, width of each register and data port.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes, never busy.
- BYPASS, 1, 1 = same-cycle write data and busy-clear are forwarded to the read ports.
- REG_READ, 0, 0 = combinational read outputs; 1 = read outputs registered, one cycle of latency.

Ports:
- CLK  in  1  clock, rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- RD_ADDR1  in  ADDR_W  read port 1 address.
- RD_ADDR2  in  ADDR_W  read port 2 address.
- RD_DATA1  out  DATA_W  read port 1 data.
- RD_DATA2  out  DATA_W  read port 2 data.
- RD_BUSY1  out  1  register at RD_ADDR1 is pending.
- RD_BUSY2  out  1  register at RD_ADDR2 is pending.
- WR_EN  in  1  write enable.
- WR_ADDR  in  ADDR_W  write address.
- WR_DATA  in  DATA_W  write data.
- BUSY_SET  in  1  mark BUSY_ADDR pending (load issued).
- BUSY_ADDR  in  ADDR_W  register to mark pending.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - All registers are cleared to 0 and all busy bits to 0.
  - With REG_READ=1, RD_DATA1/2 and RD_BUSY1/2 are 0.
  - With REG_READ=0, outputs follow the cleared contents.
  - No file-based initialisation; contents are defined only by reset and writes.
- Write:
  - On a rising CLK with WR_EN=1, reg[WR_ADDR] <= WR_DATA and busy[WR_ADDR] <= 0.
  - WR_EN=0 leaves all state unchanged regardless of WR_ADDR/WR_DATA.
- Busy set: on a rising CLK with BUSY_SET=1, busy[BUSY_ADDR] <= 1.
- Simultaneous WR_EN and BUSY_SET to the same address:
  - Data is written and the busy bit ends at 1; set wins, because the new load is younger than the retiring write.
  - Different addresses are independent.
- ZERO_REG=1, address 0:
  - Writes are discarded and BUSY_SET is ignored.
  - RD_DATA for address 0 is 0 and RD_BUSY is 0, including under bypass.
- ZERO_REG=0: address 0 is an ordinary register.
- REG_READ=0:
  - RD_DATAn = reg[RD_ADDRn] and RD_BUSYn = busy[RD_ADDRn], combinationally.
  - BYPASS=1 with WR_EN=1 and WR_ADDR==RD_ADDRn (not a ZERO_REG zero address): RD_DATAn = WR_DATA in the same cycle. RD_BUSYn = 1 only if BUSY_SET targets the same address that cycle, otherwise 0.
  - BYPASS=0: reads return pre-edge contents.
- REG_READ=1:
  - Outputs are sampled on the rising CLK, latency 1.
  - BYPASS=1: the sample is taken from post-write state, so a read of the address being written returns the new data.
  - BYPASS=0: the sample is taken from pre-write state.
- Both read ports may address the same register, and either may equal WR_ADDR; each port resolves independently.
- Address width is exact and there is no out-of-range case.
- Reset asserted mid-operation:
  - State clears immediately.
  - A write or busy-set on the edge coinciding with RESET_N=0 is dropped.
  - The first write is accepted on the first rising edge after RESET_N returns to 1.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every RD_DATA = 0x00000000 and every RD_BUSY = 0.
- WR_EN=1, WR_ADDR=5, WR_DATA=0xDEADBEEF, one edge, then RD_ADDR1=5 and RD_ADDR2=5 -> both ports read 0xDEADBEEF. Repeat with WR_ADDR=0 (ZERO_REG=1) -> reads 0.
- BYPASS=1, REG_READ=0: same cycle WR_EN=1, WR_ADDR=7, WR_DATA=0x12345678 and RD_ADDR1=7 -> RD_DATA1=0x12345678 before the edge. With BYPASS=0 -> old value before the edge, new value after it.
- BUSY_SET on reg 9, next cycle RD_ADDR2=9 -> RD_BUSY2=1. Then WR_EN on reg 9 with 0xA5A5A5A5 -> after the edge RD_BUSY2=0 and RD_DATA2=0xA5A5A5A5. BUSY_SET and WR_EN on reg 9 in the same cycle -> RD_BUSY2=1 and data updated.
- REG_READ=1: RD_ADDR1 changes from 3 to 4 -> RD_DATA1 shows reg[4] one edge later, not earlier.
- Write reg 10 = 0x55, BUSY_SET on reg 10, then assert RESET_N=0 asynchronously between edges -> reg 10 reads 0 and is not busy immediately, without waiting for a clock edge.
